elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_scheduler_floor_compare.sv | 31 +++
 rtl/elevator_scheduler.sv | 113 +++++++++++
 tb/tb_elevator_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator scheduler.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 6;

    typedef logic [5:0] floor_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } sched_state_t;

    function automatic logic floor_is_onehot(input logic [31:0] f);
        return $onehot(f);
    endfunction

endpackage

// File: rtl/elevator_scheduler_floor_compare.sv
// Classifies outstanding requests relative to the car: at, above or below it.
module floor_compare #(
    parameter int N = 6
) (
    input  logic [N-1:0] pending_i,
    input  logic [N-1:0] current_i,
    output logic         here_o,
    output logic         above_o,
    output logic         below_o
);
    logic seen;

    assign here_o = |(pending_i & current_i);

    // Bits before the car's bit are below it, bits after are above it.
    always_comb begin
        seen    = 1'b0;
        above_o = 1'b0;
        below_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (current_i[i]) begin
                seen = 1'b1;
            end else if (seen) begin
                above_o = above_o | pending_i[i];
            end else begin
                below_o = below_o | pending_i[i];
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator car scheduler: latches calls, sequences moves and door dwell.
// Optional DOOR_HOLD_EN: holdDoor keeps the door open while asserted.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NUM_FLOORS-1:0] callReq,
    input  logic [NUM_FLOORS-1:0] currentFloor,
    input  logic                  holdDoor,
    output logic                  Up,
    output logic                  Down,
    output logic                  doorOpen,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  floorError,
    output sched_state_t          state_o
);
    localparam logic [7:0] RELOAD = 8'(DOOR_CYCLES - 1);

    sched_state_t          state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, clr;
    logic [7:0]            timer_q, timer_d;
    logic                  dir_q, dir_d;
    logic                  valid, here, above, below, door_call, hold_req;

`ifdef DOOR_HOLD_EN
    assign hold_req = holdDoor;
`else
    logic unused_hold;
    assign unused_hold = holdDoor;
    assign hold_req    = 1'b0;
`endif

    floor_compare #(.N(NUM_FLOORS)) u_cmp (
        .pending_i(pending_q),
        .current_i(currentFloor),
        .here_o   (here),
        .above_o  (above),
        .below_o  (below)
    );

    assign valid      = floor_is_onehot(32'(currentFloor));
    assign floorError = ~valid;
    assign door_call  = |(callReq & currentFloor);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        if (!valid) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, MOVE_UP: begin
                    if (here)       state_d = DOOR_OPEN;
                    else if (above) state_d = MOVE_UP;
                    else if (below) state_d = MOVE_DOWN;
                    else            state_d = IDLE;
                end
                MOVE_DOWN: begin
                    if (here)       state_d = DOOR_OPEN;
                    else if (below) state_d = MOVE_DOWN;
                    else if (above) state_d = MOVE_UP;
                    else            state_d = IDLE;
                end
                DOOR_OPEN: begin
                    if (door_call || hold_req) begin
                        timer_d = RELOAD;
                    end else if (timer_q != 8'd0) begin
                        timer_d = timer_q - 8'd1;
                    end else if (dir_q) begin
                        state_d = above ? MOVE_UP : (below ? MOVE_DOWN : IDLE);
                    end else begin
                        state_d = below ? MOVE_DOWN : (above ? MOVE_UP : IDLE);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == DOOR_OPEN && state_q != DOOR_OPEN) timer_d = RELOAD;
        if (state_d == MOVE_UP)        dir_d = 1'b1;
        else if (state_d == MOVE_DOWN) dir_d = 1'b0;
    end

    // Clearing is suppressed while the position is untrustworthy; calls still latch.
    assign clr       = (valid && (state_d == DOOR_OPEN || state_q == DOOR_OPEN))
                       ? currentFloor : '0;
    assign pending_d = (pending_q | callReq) & ~clr;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            timer_q   <= 8'd0;
            dir_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
        end
    end

    assign Up       = (state_q == MOVE_UP);
    assign Down     = (state_q == MOVE_DOWN);
    assign doorOpen = (state_q == DOOR_OPEN);
    assign pending  = pending_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with hand-computed expectations.
module tb_elevator_scheduler;
    import elevator_pkg::*;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [5:0]   callReq = '0;
    logic [5:0]   currentFloor = 6'b000001;
    logic         holdDoor = 1'b0;
    logic         Up, Down, doorOpen, floorError;
    logic [5:0]   pending;
    sched_state_t state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    elevator_scheduler #(.NUM_FLOORS(6), .DOOR_CYCLES(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .callReq     (callReq),
        .currentFloor(currentFloor),
        .holdDoor    (holdDoor),
        .Up          (Up),
        .Down        (Down),
        .doorOpen    (doorOpen),
        .pending     (pending),
        .floorError  (floorError),
        .state_o     (state_o)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] cf);
        Reset = 1'b1;
        callReq = '0;
        holdDoor = 1'b0;
        currentFloor = cf;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Counts consecutive door-open cycles starting from the current one.
    task automatic measure_door(output int cnt);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!doorOpen) break;
            cnt++;
            tick();
        end
    endtask

    always @(negedge Clock) begin
        if (!Reset) check_eq("excl", 32'((Up & Down) | (doorOpen & (Up | Down))), 32'd0);
    end

    initial begin
        // Reset state and basic up trip
        do_reset(6'b000001);
        check_eq("rst_state", 32'(state_o), 32'(IDLE));
        check_eq("rst_up", 32'(Up), 32'd0);
        check_eq("rst_pend", 32'(pending), 32'd0);
        check_eq("rst_door", 32'(doorOpen), 32'd0);
        callReq = 6'b000100;
        tick();
        callReq = '0;
        check_eq("t1_pend", 32'(pending), 32'b000100);
        check_eq("t1_up_early", 32'(Up), 32'd0);
        tick();
        check_eq("t1_up", 32'(Up), 32'd1);
        currentFloor = 6'b000010;
        tick();
        check_eq("t1_up_mid", 32'(Up), 32'd1);
        currentFloor = 6'b000100;
        tick();
        check_eq("t1_door", 32'(doorOpen), 32'd1);
        check_eq("t1_pend_clr", 32'(pending), 32'd0);
        measure_door(n);
        check_eq("t1_dwell", 32'(n), 32'd4);
        check_eq("t1_idle", 32'(state_o), 32'(IDLE));

        // Moving up from floor 3 with calls on both ends
        do_reset(6'b001000);
        callReq = 6'b100000;
        tick();
        callReq = '0;
        tick();
        check_eq("t2_up", 32'(Up), 32'd1);
        callReq = 6'b100001;
        tick();
        callReq = '0;
        check_eq("t2_pend", 32'(pending), 32'b100001);
        check_eq("t2_still_up", 32'(Up), 32'd1);
        currentFloor = 6'b010000;
        tick();
        currentFloor = 6'b100000;
        tick();
        check_eq("t2_door_top", 32'(doorOpen), 32'd1);
        check_eq("t2_pend_top", 32'(pending), 32'b000001);
        measure_door(n);
        check_eq("t2_dwell_top", 32'(n), 32'd4);
        check_eq("t2_down", 32'(Down), 32'd1);
        currentFloor = 6'b010000; tick();
        currentFloor = 6'b001000; tick();
        currentFloor = 6'b000100; tick();
        currentFloor = 6'b000010; tick();
        check_eq("t2_down_mid", 32'(Down), 32'd1);
        currentFloor = 6'b000001; tick();
        check_eq("t2_door_bot", 32'(doorOpen), 32'd1);
        check_eq("t2_pend_bot", 32'(pending), 32'd0);
        measure_door(n);
        check_eq("t2_dwell_bot", 32'(n), 32'd4);
        check_eq("t2_idle", 32'(state_o), 32'(IDLE));

        // Same-floor call late in the dwell restarts it
        do_reset(6'b000010);
        callReq = 6'b000010;
        tick();
        callReq = '0;
        tick();
        check_eq("t3_door", 32'(doorOpen), 32'd1);
        tick();
        tick();
        check_eq("t3_door_t1", 32'(doorOpen), 32'd1);
        callReq = 6'b000010;
        tick();
        callReq = '0;
        check_eq("t3_pend", 32'(pending), 32'd0);
        measure_door(n);
        check_eq("t3_extend", 32'(n), 32'd4);

        // Non-one-hot position
        do_reset(6'b000001);
        callReq = 6'b001000;
        tick();
        callReq = '0;
        tick();
        check_eq("t4_up", 32'(Up), 32'd1);
        currentFloor = 6'b000110;
        callReq = 6'b100000;
        #1;
        check_eq("t4_err", 32'(floorError), 32'd1);
        tick();
        callReq = '0;
        check_eq("t4_idle", 32'(state_o), 32'(IDLE));
        check_eq("t4_updown", 32'({Up, Down}), 32'd0);
        check_eq("t4_pend", 32'(pending), 32'b101000);
        currentFloor = 6'b000100;
        #1;
        check_eq("t4_err_clr", 32'(floorError), 32'd0);
        tick();
        check_eq("t4_resume", 32'(Up), 32'd1);

        // Reset mid-move
        do_reset(6'b000001);
        callReq = 6'b110000;
        tick();
        callReq = '0;
        tick();
        check_eq("t5_up", 32'(Up), 32'd1);
        Reset = 1'b1;
        tick();
        check_eq("t5_up_rst", 32'(Up), 32'd0);
        check_eq("t5_pend_rst", 32'(pending), 32'd0);
        check_eq("t5_state_rst", 32'(state_o), 32'(IDLE));
        Reset = 1'b0;

        // Call below from idle
        do_reset(6'b000100);
        callReq = 6'b000001;
        tick();
        callReq = '0;
        check_eq("t6_down_early", 32'(Down), 32'd0);
        tick();
        check_eq("t6_down", 32'(Down), 32'd1);

        // Door hold button
        do_reset(6'b000001);
        callReq = 6'b000001;
        tick();
        callReq = '0;
        tick();
        check_eq("t7_door", 32'(doorOpen), 32'd1);
        n = 0;
        holdDoor = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (!doorOpen) break;
            n++;
            holdDoor = (n <= 10);
            tick();
        end
        holdDoor = 1'b0;
`ifdef DOOR_HOLD_EN
        check_eq("t7_hold", 32'(n), 32'd14);
`else
        check_eq("t7_hold", 32'(n), 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
